// File: rtl/mitchell_pkg.sv
// Shared widths and the encoded-log type for the Mitchell multiplier datapath.
package mitchell_pkg;
  localparam int DATA_W = 8;
  localparam int K_W    = $clog2(DATA_W);
  localparam int FRAC_W = DATA_W - 1;

  typedef logic [K_W+FRAC_W-1:0] log_code_t;
endpackage

// File: rtl/mitchell_log_encoder_if.sv
// Operand-in / log-code-out bundle for one Mitchell encoder lane.
interface mitchell_log_encoder_if;
  import mitchell_pkg::*;

  logic              in_valid;
  logic [DATA_W-1:0] a;
  logic              out_valid;
  log_code_t         c;
  logic              zero;

  modport master (output in_valid, output a, input out_valid, input c, input zero);
  modport slave  (input in_valid, input a, output out_valid, output c, output zero);
endinterface

// File: rtl/lod_priority_enc.sv
// Leading-one detector: index of the most-significant set bit plus a nonzero flag.
module lod_priority_enc #(
  parameter int W  = 8,
  parameter int KW = $clog2(W)
) (
  input  logic [W-1:0]  a,
  output logic [KW-1:0] k,
  output logic          nonzero
);
  always_comb begin
    k       = '0;
    nonzero = |a;
    // Ascending scan: the last hit wins, giving the MSB index.
    for (int unsigned i = 0; i < W; i++) begin
      if (a[i]) k = KW'(i);
    end
  end
endmodule

// File: rtl/mitchell_log_encoder.sv
// Mitchell log2 encoder: registers c = {k, fraction} one cycle after in_valid.
module mitchell_log_encoder
  import mitchell_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  mitchell_log_encoder_if.slave  bus
);
  localparam logic [K_W-1:0] FRAC_SH = K_W'(FRAC_W);

  logic [K_W-1:0]    k;
  logic              nonzero;
  logic [FRAC_W-1:0] frac;
  log_code_t         c_next;

  lod_priority_enc #(.W(DATA_W), .KW(K_W)) u_lod (
    .a       (bus.a),
    .k       (k),
    .nonzero (nonzero)
  );

  // The leading one drops off the top; only bits below it survive into frac.
  always_comb begin
    frac   = bus.a[FRAC_W-1:0] << (FRAC_SH - k);
    c_next = {k, frac};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.c         <= '0;
      bus.zero      <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.c    <= c_next;
        bus.zero <= ~nonzero;
      end
    end
  end
endmodule

// File: tb/tb_mitchell_log_encoder.sv
// Self-checking bench for mitchell_log_encoder against an arithmetic log2 model.
module tb_mitchell_log_encoder;
  import mitchell_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  mitchell_log_encoder_if bus ();

  mitchell_log_encoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic int unsigned model_c(int unsigned v);
    int unsigned k;
    k = 0;
    if (v == 0) return 0;
    while ((1 << (k + 1)) <= v) k++;
    return k * 128 + (v - (1 << k)) * (1 << (7 - k));
  endfunction

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cycle_in(input logic v, input int unsigned val);
    @(negedge clk);
    bus.in_valid = v;
    bus.a        = val[7:0];
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input int unsigned val);
    chk({tag, "_valid"}, 32'(bus.out_valid), 1);
    chk({tag, "_c"},     32'(bus.c),         model_c(val));
    chk({tag, "_zero"},  32'(bus.zero),      (val == 0) ? 1 : 0);
  endtask

  initial begin
    int unsigned last_c;
    int unsigned last_z;
    logic        v;
    int unsigned r;

    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    #1;
    chk("reset_valid", 32'(bus.out_valid), 0);
    chk("reset_c",     32'(bus.c),         0);
    chk("reset_zero",  32'(bus.zero),      0);
    @(negedge clk);
    rst = 1'b0;

    // Directed small, mid and max values
    cycle_in(1'b1, 1);   expect_out("a1", 1);   chk("a1_lit", 32'(bus.c), 0);
    cycle_in(1'b1, 2);   expect_out("a2", 2);   chk("a2_lit", 32'(bus.c), 128);
    cycle_in(1'b1, 3);   expect_out("a3", 3);   chk("a3_lit", 32'(bus.c), 192);
    cycle_in(1'b1, 100); expect_out("a100", 100); chk("a100_lit", 32'(bus.c), 840);
    cycle_in(1'b1, 128); expect_out("a128", 128); chk("a128_lit", 32'(bus.c), 896);
    cycle_in(1'b1, 255); expect_out("a255", 255); chk("a255_lit", 32'(bus.c), 1023);

    // Zero operand followed by a normal one
    cycle_in(1'b1, 0);   expect_out("a0", 0);
    chk("a0_zero_lit", 32'(bus.zero), 1);
    cycle_in(1'b1, 5);   expect_out("a5", 5);   chk("a5_lit", 32'(bus.c), 288);

    // Back-to-back sweep of every nonzero operand
    for (int unsigned i = 1; i < 256; i++) begin
      cycle_in(1'b1, i);
      expect_out("sweep", i);
    end

    // Hold after in_valid drops
    cycle_in(1'b1, 200); expect_out("a200", 200);
    cycle_in(1'b0, 17);
    chk("hold_valid", 32'(bus.out_valid), 0);
    chk("hold_c",     32'(bus.c),         968);
    chk("hold_zero",  32'(bus.zero),      0);
    cycle_in(1'b0, 0);
    chk("hold2_c",    32'(bus.c),         968);

    // Randomized valid/operand traffic
    last_c = 968;
    last_z = 0;
    for (int n = 0; n < 300; n++) begin
      v = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 255);
      if (n % 37 == 0) r = 0;
      cycle_in(v, r);
      if (v) begin
        last_c = model_c(r);
        last_z = (r == 0) ? 1 : 0;
      end
      chk("rand_valid", 32'(bus.out_valid), 32'(v));
      chk("rand_c",     32'(bus.c),         last_c);
      chk("rand_zero",  32'(bus.zero),      last_z);
    end

    // Asynchronous reset mid-cycle with live traffic
    cycle_in(1'b1, 77);
    expect_out("pre_rst", 77);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(bus.out_valid), 0);
    chk("async_rst_c",     32'(bus.c),         0);
    chk("async_rst_zero",  32'(bus.zero),      0);
    @(negedge clk);
    rst = 1'b0;
    cycle_in(1'b1, 9);
    expect_out("post_rst", 9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
